gpr_xfer_ctrl: RTL and testbench
================================

# gpr_xfer_ctrl

Register-transfer initiator for the 24-bit general-purpose register bank. It accepts one transfer command at a time: MOV, LOADI, INC or CLR. It sequences the bank's `read`/`write` strobes and select lines to carry out the command, then reports the written value with a one-cycle `done` pulse. It sits between instruction decode and the GPR bank, and is the side that drives the strobes the registers respond to.

## Interface
- `DATA_W`, 24, register data width
- `NREG`, 8, number of registers in the bank
- `ADDR_W`, 3, select width (`$clog2(NREG)`)

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: command request, sampled only in IDLE.
- `op` in 2: 00 MOV, 01 LOADI, 10 INC, 11 CLR.
- `src_sel` in ADDR_W: source register (MOV/INC).
- `dst_sel` in ADDR_W: destination register.
- `imm` in DATA_W: immediate (LOADI).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the DONE state.
- `result` out DATA_W: last value written; held until the next DONE.
- `gpr_read` out 1: read strobe to the bank.
- `gpr_rd_sel` out ADDR_W: register being read.
- `gpr_rdata` in DATA_W: bank read data; valid on the edge after `gpr_read` is sampled high.
- `gpr_write` out 1: write strobe; the bank captures on the same edge.
- `gpr_wr_sel` out ADDR_W: register being written.
- `gpr_wdata` out DATA_W: write data.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE. All outputs are registered or decoded from the state register only.
- IDLE with `start`=1:
  - Latch `op`, `src_sel`, `dst_sel`, `imm` into command registers.
  - MOV/INC go to READ; LOADI/CLR go to WRITE.
  - Inputs changing after acceptance have no effect.
- READ: `gpr_read`=1 and `gpr_rd_sel`=latched src for exactly one cycle, then CAPTURE.
- CAPTURE: sample `gpr_rdata` into the data latch, then WRITE.
- WRITE: `gpr_write`=1 and `gpr_wr_sel`=latched dst for exactly one cycle, then DONE. `gpr_wdata` is:
  - MOV: captured data.
  - INC: captured + 1, truncated to DATA_W; 24'hFFFFFF wraps to 24'h000000 with no carry out.
  - LOADI: latched `imm`.
  - CLR: 0.
- DONE: `done`=1 and `result` updates to the written value, then IDLE.
- `start` in any non-IDLE state is ignored; it is not queued.
- `src_sel`==`dst_sel` is legal (for example, in-place INC).
- `gpr_read` and `gpr_write` are never high in the same cycle.
- Outside READ, `gpr_rd_sel`=0. Outside WRITE, `gpr_wr_sel`=0 and `gpr_wdata`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State becomes IDLE.
  - `busy`, `done`, `gpr_read`, `gpr_write` = 0.
  - `gpr_rd_sel`, `gpr_wr_sel`, `gpr_wdata`, `result` = 0.
  - Command registers are cleared.
- Reset mid-command aborts it. No further strobe is issued after that edge, and no `done` is produced.
- Reset has priority over `start`.
- With `start` sampled at edge k:
  - MOV/INC: `gpr_read` high in cycle k+1, CAPTURE in k+2, `gpr_write` in k+3, `done` in k+4. Latency is 4 cycles.
  - LOADI/CLR: `gpr_write` high in cycle k+1, `done` in k+2. Latency is 2 cycles.
- `busy` rises in cycle k+1 and falls the cycle after DONE.
- Earliest next accepted `start` is the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- Back-to-back MOV throughput is one command per 5 cycles.

## Test plan
- Reset then LOADI:
  - Hold `rst_n`=0 for 2 cycles and check every output is 0.
  - LOADI `imm`=24'd100, `dst_sel`=2 → `gpr_write` for one cycle with `gpr_wr_sel`=2, `gpr_wdata`=100; `done` 2 cycles after `start`; `result`=100.
- MOV:
  - Bank model R5=24'hABCDEF. MOV src=5, dst=1 → `gpr_read` with `gpr_rd_sel`=5 at k+1; `gpr_write` with `gpr_wr_sel`=1, `gpr_wdata`=24'hABCDEF at k+3; `done` at k+4.
- INC wrap:
  - R3=24'hFFFFFF, INC src=3, dst=3 → `gpr_wdata`=0, `result`=0.
  - R3=24'd41 → `gpr_wdata`=42.
- Busy handling:
  - Assert `start`=1 with CLR every cycle during a MOV → only the first command executes; `done` pulses once.
  - The next command is accepted in the first IDLE cycle.
- Reset mid-operation:
  - Drop `rst_n` in the CAPTURE cycle of a MOV → `gpr_write` never asserts, `done` stays 0, `busy`=0 after the edge.
- Strobe exclusivity:
  - Random 200-command stream against the bank model → `gpr_read`&`gpr_write` never both high.
  - Each strobe is exactly one cycle wide.
  - The final bank contents match the reference model.

Source files
------------

// File: rtl/gpr_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// gpr_xfer_ctrl
// Register-transfer initiator for the general-purpose register bank. It takes
// one command at a time (MOV, LOADI, INC, CLR) and drives the bank read and
// write strobes to carry it out. It then reports the written value with a
// one-cycle done pulse.
//
// Ports
//   clk_i, rst_n_i      : clock and synchronous active-low reset
//   start_i, op_i       : command request and opcode (00 MOV, 01 LOADI,
//                         10 INC, 11 CLR); sampled only in IDLE
//   src_sel_i           : source register (MOV/INC)
//   dst_sel_i           : destination register
//   imm_i               : immediate value (LOADI)
//   busy_o, done_o      : busy in every state except IDLE; done pulses in DONE
//   result_o            : last written value, held until the next DONE
//   gpr_read_o          : bank read strobe
//   gpr_rd_sel_o        : bank read select
//   gpr_rdata_i         : bank read data, valid the cycle after the read strobe
//   gpr_write_o         : bank write strobe
//   gpr_wr_sel_o        : bank write select
//   gpr_wdata_o         : bank write data
// ---------------------------------------------------------------------------
module gpr_xfer_ctrl #(
    parameter int DATA_W = 24,
    parameter int NREG   = 8,
    parameter int ADDR_W = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] src_sel_i,
    input  logic [ADDR_W-1:0] dst_sel_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              gpr_read_o,
    output logic [ADDR_W-1:0] gpr_rd_sel_o,
    input  logic [DATA_W-1:0] gpr_rdata_i,
    output logic              gpr_write_o,
    output logic [ADDR_W-1:0] gpr_wr_sel_o,
    output logic [DATA_W-1:0] gpr_wdata_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE
    } state_e;

    localparam logic [1:0] OP_MOV   = 2'b00;
    localparam logic [1:0] OP_LOADI = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    state_e            state_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] wdata_d;

    // Value the current command writes; INC drops the carry out of the top bit.
    always_comb begin
        wdata_d = '0;
        unique case (op_q)
            OP_MOV:   wdata_d = data_q;
            OP_INC:   wdata_d = data_q + DATA_W'(1);
            OP_LOADI: wdata_d = imm_q;
            OP_CLR:   wdata_d = '0;
            default:  wdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        src_q <= src_sel_i;
                        dst_q <= dst_sel_i;
                        imm_q <= imm_i;
                        // Only MOV and INC need the source register.
                        state_q <= (op_i == OP_MOV || op_i == OP_INC) ? S_READ : S_WRITE;
                    end
                end
                S_READ:    state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    data_q  <= gpr_rdata_i;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    // result changes on entry to DONE, when done goes high.
                    result_q <= wdata_d;
                    state_q  <= S_DONE;
                end
                S_DONE:    state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // All outputs decode straight from the state flop and the command
    // registers, so selects and data read as zero outside their strobe cycle.
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign result_o     = result_q;
    assign gpr_read_o   = (state_q == S_READ);
    assign gpr_rd_sel_o = (state_q == S_READ)  ? src_q   : '0;
    assign gpr_write_o  = (state_q == S_WRITE);
    assign gpr_wr_sel_o = (state_q == S_WRITE) ? dst_q   : '0;
    assign gpr_wdata_o  = (state_q == S_WRITE) ? wdata_d : '0;

endmodule

// File: tb/tb_gpr_xfer_ctrl.sv
module tb_gpr_xfer_ctrl;
    localparam int DATA_W = 24;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] src_sel, dst_sel;
    logic [DATA_W-1:0] imm;
    logic              busy, done;
    logic [DATA_W-1:0] result;
    logic              gpr_read, gpr_write;
    logic [ADDR_W-1:0] gpr_rd_sel, gpr_wr_sel;
    logic [DATA_W-1:0] gpr_rdata, gpr_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpr_xfer_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .src_sel_i(src_sel), .dst_sel_i(dst_sel), .imm_i(imm),
        .busy_o(busy), .done_o(done), .result_o(result),
        .gpr_read_o(gpr_read), .gpr_rd_sel_o(gpr_rd_sel), .gpr_rdata_i(gpr_rdata),
        .gpr_write_o(gpr_write), .gpr_wr_sel_o(gpr_wr_sel), .gpr_wdata_o(gpr_wdata)
    );

    // Bank model: registered read data, write on the strobe edge, plus a
    // preload port the stimulus uses to seed register contents.
    logic [DATA_W-1:0] bank [NREG];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_idx = '0;
    logic [DATA_W-1:0] pl_val = '0;

    always @(posedge clk) begin
        if (gpr_read)  gpr_rdata <= bank[gpr_rd_sel];
        if (gpr_write) bank[gpr_wr_sel] <= gpr_wdata;
        if (pl_en)     bank[pl_idx] <= pl_val;
    end

    // Strobe monitor: overlap and width violations.
    int   overlap = 0, wide = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin
        if (gpr_read && gpr_write)  overlap <= overlap + 1;
        if (gpr_read && prev_rd)    wide    <= wide + 1;
        if (gpr_write && prev_wr)   wide    <= wide + 1;
        prev_rd <= gpr_read;
        prev_wr <= gpr_write;
    end

    logic [DATA_W-1:0] ref_m [NREG];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [DATA_W-1:0] v);
        pl_en = 1'b1; pl_idx = ADDR_W'(idx); pl_val = v;
        tick();
        pl_en = 1'b0;
        ref_m[idx] = v;
    endtask

    task automatic issue(input logic [1:0] o, input int s, input int d, input logic [DATA_W-1:0] im);
        op = o; src_sel = ADDR_W'(s); dst_sel = ADDR_W'(d); imm = im; start = 1'b1;
        tick();
        start = 1'b0; op = '0; src_sel = '0; dst_sel = '0; imm = '0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 10) begin tick(); n++; end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int dones, writes;
        logic [1:0]        ro;
        int                rs, rd;
        logic [DATA_W-1:0] rim, rexp;

        rst_n = 1'b0; start = 1'b0; op = '0; src_sel = '0; dst_sel = '0; imm = '0;
        for (int i = 0; i < NREG; i++) ref_m[i] = '0;
        tick(); tick();
        chk("rst_busy",   {31'd0, busy}, 0);
        chk("rst_done",   {31'd0, done}, 0);
        chk("rst_read",   {31'd0, gpr_read}, 0);
        chk("rst_write",  {31'd0, gpr_write}, 0);
        chk("rst_rdsel",  32'(gpr_rd_sel), 0);
        chk("rst_wrsel",  32'(gpr_wr_sel), 0);
        chk("rst_wdata",  32'(gpr_wdata), 0);
        chk("rst_result", 32'(result), 0);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) preload(i, '0);

        // LOADI 100 -> R2: write in k+1, done in k+2.
        issue(2'b01, 0, 2, 24'd100);
        chk("ldi_busy",  {31'd0, busy}, 1);
        chk("ldi_write", {31'd0, gpr_write}, 1);
        chk("ldi_wrsel", 32'(gpr_wr_sel), 2);
        chk("ldi_wdata", 32'(gpr_wdata), 100);
        tick();
        chk("ldi_done",   {31'd0, done}, 1);
        chk("ldi_wr_off", {31'd0, gpr_write}, 0);
        chk("ldi_result", 32'(result), 100);
        tick();
        chk("ldi_idle", {31'd0, busy}, 0);
        chk("ldi_dpls", {31'd0, done}, 0);
        ref_m[2] = 24'd100;

        // MOV R5 -> R1.
        preload(5, 24'hABCDEF);
        issue(2'b00, 5, 1, 24'h123456);
        chk("mov_read",  {31'd0, gpr_read}, 1);
        chk("mov_rdsel", 32'(gpr_rd_sel), 5);
        chk("mov_nowr",  {31'd0, gpr_write}, 0);
        tick();
        chk("mov_cap_rd", {31'd0, gpr_read}, 0);
        chk("mov_cap_rdsel", 32'(gpr_rd_sel), 0);
        tick();
        chk("mov_write", {31'd0, gpr_write}, 1);
        chk("mov_wrsel", 32'(gpr_wr_sel), 1);
        chk("mov_wdata", 32'(gpr_wdata), 32'hABCDEF);
        tick();
        chk("mov_done",   {31'd0, done}, 1);
        chk("mov_result", 32'(result), 32'hABCDEF);
        chk("mov_wd0",    32'(gpr_wdata), 0);
        tick();
        ref_m[1] = 24'hABCDEF;

        // INC in place with wrap, then a normal increment.
        preload(3, 24'hFFFFFF);
        issue(2'b10, 3, 3, '0);
        tick(); tick();
        chk("incw_wdata", 32'(gpr_wdata), 0);
        tick();
        chk("incw_result", 32'(result), 0);
        tick();
        preload(3, 24'd41);
        issue(2'b10, 3, 3, '0);
        tick(); tick();
        chk("inc_wdata", 32'(gpr_wdata), 42);
        tick();
        chk("inc_result", 32'(result), 42);
        tick();
        ref_m[3] = 24'd42;

        // CLR requests held during a MOV are ignored until the first IDLE cycle.
        preload(6, 24'h777777);
        preload(5, 24'h00BEEF);
        op = 2'b00; src_sel = 3'd5; dst_sel = 3'd1; start = 1'b1;
        tick();
        op = 2'b11; src_sel = 3'd0; dst_sel = 3'd6;
        dones = 0; writes = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            if (gpr_write) begin
                writes++;
                chk("busy_wsel",  32'(gpr_wr_sel), 1);
                chk("busy_wdata", 32'(gpr_wdata), 32'h00BEEF);
            end
            tick();
        end
        chk("busy_dones",  32'(dones), 1);
        chk("busy_writes", 32'(writes), 1);
        chk("busy_idle",   {31'd0, busy}, 0);
        tick();
        start = 1'b0;
        chk("next_write", {31'd0, gpr_write}, 1);
        chk("next_wrsel", 32'(gpr_wr_sel), 6);
        tick();
        chk("next_done", {31'd0, done}, 1);
        chk("next_res",  32'(result), 0);
        tick();
        ref_m[1] = 24'h00BEEF; ref_m[5] = 24'h00BEEF; ref_m[6] = '0;

        // Reset in the CAPTURE cycle of a MOV aborts it.
        issue(2'b00, 2, 4, '0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy",  {31'd0, busy}, 0);
        chk("abort_write", {31'd0, gpr_write}, 0);
        rst_n = 1'b1;
        dones = 0; writes = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            if (gpr_write) writes++;
            tick();
        end
        chk("abort_dones",  32'(dones), 0);
        chk("abort_writes", 32'(writes), 0);
        chk("abort_result", 32'(result), 0);

        // Random command stream against the reference model.
        for (int i = 0; i < NREG; i++) preload(i, 24'($urandom));
        for (int n = 0; n < 200; n++) begin
            ro = 2'($urandom_range(0, 3));
            rs = $urandom_range(0, NREG - 1);
            rd = $urandom_range(0, NREG - 1);
            rim = 24'($urandom);
            case (ro)
                2'b00:   rexp = ref_m[rs];
                2'b10:   rexp = ref_m[rs] + 24'd1;
                2'b01:   rexp = rim;
                default: rexp = '0;
            endcase
            ref_m[rd] = rexp;
            issue(ro, rs, rd, rim);
            wait_done("rnd_done");
            chk("rnd_result", 32'(result), 32'(rexp));
            tick();
        end
        for (int i = 0; i < NREG; i++) chk("bank_final", 32'(bank[i]), 32'(ref_m[i]));
        chk("strobe_overlap", 32'(overlap), 0);
        chk("strobe_width",   32'(wide), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
